uart_port: RTL and testbench
============================

// Module: uart_port
// PURPOSE
//  CPU-mapped byte-serial port: 8N1 UART with parametrised TX/RX FIFOs, sticky
//  error flags, interrupt enables and an RX fill count. Sits on the CPU peripheral
//  bus (CE/REN/WREN strobes, 2-bit address) next to the PS/2 keyboard port.
//  Carries the same status-word layout, with more registers and an integrated serial engine.
// PARAMETERS
//  CLK_DIV   434  clk cycles per bit (>=4); 434 = 115200 baud @ 50 MHz
//  TX_DEPTH  16   TX FIFO entries, power of 2, 2..256
//  RX_DEPTH  16   RX FIFO entries, power of 2, 2..256
// PORTS
//  clk      in   1  clock, all logic posedge
//  reset    in   1  asynchronous, active-high
//  A        in   2  register address
//  CE       in   1  chip enable; REN/WREN ignored when 0
//  REN      in   1  read strobe (one cycle per access)
//  WREN     in   1  write strobe (one cycle per access)
//  from_CPU in   8  write data
//  to_CPU   out  8  registered read data
//  rxd      in   1  serial in, asynchronous, idle high
//  txd      out  1  serial out, idle high
//  irq      out  1  level interrupt
// BEHAVIOUR
//  Reset: to_CPU=0x00, txd=1, irq=0, CTRL=0, FIFOs empty, sticky flags 0, both engines idle.
//  Map: A=0 R pop RX / W push TX; A=1 R STATUS (clears sticky) / W ignored;
//   A=2 R/W CTRL {6'b0,tx_ie,rx_ie}; A=3 R RX count (saturates at 255), W ignored.
//  to_CPU updates every clk from A; read data valid 1 cycle after REN strobe.
//   A=0 returns the RX head and the pop occurs on the REN cycle. Empty RX:
//   returns 0x00, no pop, no flag.
//  STATUS = {perr, ferr, rx_full, tx_idle, rx_nempty, tx_nfull, rx_ovr, tx_ovr};
//   tx_idle = TX FIFO empty and TX engine idle.
//  Sticky (tx_ovr, rx_ovr, ferr, perr): a STATUS read clears them; a same-cycle set wins.
//  TX push when full: byte dropped, tx_ovr=1. RX byte arriving when full: byte
//   dropped, rx_ovr=1. If the RX FIFO is full and the CPU pops in the same cycle
//   the byte arrives, the byte is accepted, count is unchanged and no overrun is set.
//  FIFOs: circular, log2(DEPTH) pointers wrap naturally; count width log2(DEPTH)+1.
//  TX FSM IDLE->START->DATA(8, LSB first)->[PARITY]->STOP->IDLE; each state CLK_DIV clks.
//   IDLE pops FIFO when non-empty. Next frame starts the cycle after STOP ends, so there is no idle gap.
//  RX: rxd through a 2-flop synchroniser. FSM IDLE->START->DATA->[PARITY]->STOP.
//   A falling edge in IDLE enters START. Start is sampled at CLK_DIV/2; if high,
//   the FSM aborts to IDLE as a glitch. Subsequent samples come every CLK_DIV.
//   Stop sampled 0: ferr=1, byte discarded, FSM returns to IDLE only after rxd high.
//  irq = (rx_ie & rx_nempty) | (tx_ie & tx_idle); combinational from registers.
//  Reset mid-frame aborts both engines; txd returns high immediately (async).
//  CTRL write takes effect on the next clk; FIFO contents are unaffected.
// CONFIGURATION
//  UART_PARITY_EN defined: even parity bit after the data bits, in both
//   directions (frame = 11 bits). An RX parity mismatch sets perr and discards the byte.
//  Undefined: 8N1 (frame = 10 bits), no parity logic, STATUS bit7 reads 0.
// TESTING (CLK_DIV=8, depths 4)
//  1 Write 0x55 to A=0 -> txd 0,1,0,1,0,1,0,1,0,1 at 8-clk bits. STATUS bit4 is 0
//    during the frame and 1 after.
//  2 Loop txd->rxd, write 0xA3 -> RX count=1, irq=1 with rx_ie; A=0 read gives
//    0xA3 and count then reads 0.
//  3 Write 6 bytes back to back with the line busy -> first popped, 4 queued,
//    6th dropped; STATUS=0x01 (tx_ovr); second STATUS read shows tx_ovr=0.
//  4 Receive 5 bytes without reading -> rx_full=1, rx_ovr=1; pops return the first
//    4 bytes in order, then 0x00.
//  5 Drive stop bit low -> ferr=1, count unchanged. Send a 2-clk low glitch -> no
//    byte, no flag.
//  6 Assert reset mid-TX frame -> txd=1 at once, FIFOs empty, CTRL=0x00.
//    UART_PARITY_EN: send 0x07 with odd parity -> perr=1, no byte.

Source files
------------

// File: rtl/uart_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_port_if
//  Purpose  : CPU peripheral-bus bundle for uart_port. Carries the register
//             address, chip enable, one-cycle read/write strobes, write data,
//             registered read data and the level interrupt.
//  Ports    : A[1:0], CE, REN, WREN, from_CPU[7:0]  (CPU -> port)
//             to_CPU[7:0], irq                      (port -> CPU)
//  Modports : master = CPU side, slave = uart_port side
//  Revision : 1.0  initial release
// ============================================================================
interface uart_port_if;
  logic [1:0] A;
  logic       CE;
  logic       REN;
  logic       WREN;
  logic [7:0] from_CPU;
  logic [7:0] to_CPU;
  logic       irq;

  modport master (output A, CE, REN, WREN, from_CPU, input  to_CPU, irq);
  modport slave  (input  A, CE, REN, WREN, from_CPU, output to_CPU, irq);
endinterface
`default_nettype wire

// File: rtl/uart_port.sv
`default_nettype none
// ============================================================================
//  Module   : uart_port
//  Purpose  : CPU-mapped UART (8N1, or 8E1 when UART_PARITY_EN is defined)
//             with TX/RX FIFOs, sticky error flags, interrupt enables and an
//             RX fill count.
//  Ports    : clk    - clock, all logic on posedge
//             reset  - asynchronous, active-high
//             bus    - uart_port_if.slave (A, CE, REN, WREN, from_CPU,
//                      to_CPU, irq)
//             rxd    - serial in, asynchronous, idle high
//             txd    - serial out, idle high
//  Registers: A=0 R pop RX / W push TX   A=1 R STATUS (clears sticky flags)
//             A=2 R/W CTRL {6'b0,tx_ie,rx_ie}   A=3 R RX count (sat. 255)
//  STATUS   : {perr, ferr, rx_full, tx_idle, rx_nempty, tx_nfull, rx_ovr, tx_ovr}
//  Macro    : UART_PARITY_EN - adds an even parity bit in both directions
//  Revision : 1.0  initial release
// ============================================================================
module uart_port #(
  parameter int CLK_DIV  = 434,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  wire        clk,
  input  wire        reset,
  uart_port_if.slave bus,
  input  wire        rxd,
  output logic       txd
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_CW = RX_AW + 1;
  localparam int CW    = $clog2(CLK_DIV);

  localparam logic [CW-1:0]    C_BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    C_HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [TX_CW-1:0] C_TX_FULL   = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] C_RX_FULL   = RX_CW'(RX_DEPTH);

  // ------------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------------
  logic w_rd, w_wr, w_rx_pop, w_stat_rd, w_tx_push_req, w_ctrl_wr;

  assign w_rd          = bus.CE & bus.REN;
  assign w_wr          = bus.CE & bus.WREN;
  assign w_stat_rd     = w_rd & (bus.A == 2'd1);
  assign w_tx_push_req = w_wr & (bus.A == 2'd0);
  assign w_ctrl_wr     = w_wr & (bus.A == 2'd2);

  // ------------------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
  logic [TX_CW-1:0] r_tx_count;
  logic             w_tx_full, w_tx_push, w_tx_pop, w_tx_idle;
  logic [7:0]       w_tx_head;

  assign w_tx_full = (r_tx_count == C_TX_FULL);
  assign w_tx_push = w_tx_push_req & ~w_tx_full;
  assign w_tx_head = tx_mem[r_tx_rp];

  always_ff @(posedge clk) begin
    if (w_tx_push) tx_mem[r_tx_wp] <= bus.from_CPU;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // TX engine
  // ------------------------------------------------------------------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  tx_state_t    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]   r_tx_bit;
  logic [7:0]   r_tx_shift;
  logic         w_tx_tick;
`ifdef UART_PARITY_EN
  logic         r_tx_par;
`endif

  assign w_tx_tick = (r_tx_cnt == C_BIT_LAST);
  // A frame is fetched from IDLE, or straight out of the last STOP cycle so
  // back-to-back frames carry no idle gap.
  assign w_tx_pop  = (r_tx_count != '0) &&
                     ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_tick));
  assign w_tx_idle = (r_tx_count == '0) && (r_tx_state == TX_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      txd        <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
`ifdef UART_PARITY_EN
            r_tx_par   <= ^w_tx_head;
`endif
            txd        <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START, TX_DATA, TX_PAR, TX_STOP: begin
          if (!w_tx_tick) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
              TX_START: begin
                txd        <= r_tx_shift[0];
                r_tx_bit   <= 3'd0;
                r_tx_state <= TX_DATA;
              end
              TX_DATA: begin
                if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                  txd        <= r_tx_par;
                  r_tx_state <= TX_PAR;
`else
                  txd        <= 1'b1;
                  r_tx_state <= TX_STOP;
`endif
                end else begin
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  txd        <= r_tx_shift[1];
                  r_tx_bit   <= r_tx_bit + 3'd1;
                end
              end
              TX_PAR: begin
                txd        <= 1'b1;
                r_tx_state <= TX_STOP;
              end
              default: begin
                if (w_tx_pop) begin
                  r_tx_shift <= w_tx_head;
`ifdef UART_PARITY_EN
                  r_tx_par   <= ^w_tx_head;
`endif
                  txd        <= 1'b0;
                  r_tx_state <= TX_START;
                end else begin
                  txd        <= 1'b1;
                  r_tx_state <= TX_IDLE;
                end
              end
            endcase
          end
        end
        default: begin
          txd        <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // RX synchroniser and engine
  // ------------------------------------------------------------------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;

  logic          r_rx_s1, r_rx_s2, r_rx_s3;  // s3 is the previous s2, for edge detect
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_valid, r_ferr_set;
  logic          w_rx_tick;
`ifdef UART_PARITY_EN
  logic          r_rx_par, r_perr_set;
`endif

  assign w_rx_tick = (r_rx_cnt == C_BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_ferr_set <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
      r_perr_set <= 1'b0;
`endif
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_valid <= 1'b0;
      r_ferr_set <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr_set <= 1'b0;
`endif
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_s3 && !r_rx_s2) r_rx_state <= RX_START;
        end
        RX_START: begin
          // Mid-start sample; a high line here was only a glitch.
          if (r_rx_cnt == C_HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA, RX_PAR, RX_STOP: begin
          if (!w_rx_tick) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end else begin
            r_rx_cnt <= '0;
            case (r_rx_state)
              RX_DATA: begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                  r_rx_state <= RX_PAR;
`else
                  r_rx_state <= RX_STOP;
`endif
                end
              end
              RX_PAR: begin
`ifdef UART_PARITY_EN
                r_rx_par   <= r_rx_s2;
`endif
                r_rx_state <= RX_STOP;
              end
              default: begin
                if (!r_rx_s2) begin
                  r_ferr_set <= 1'b1;
                  r_rx_state <= RX_BREAK;
                end else begin
`ifdef UART_PARITY_EN
                  if (^{r_rx_shift, r_rx_par}) r_perr_set <= 1'b1;
                  else                         r_rx_valid <= 1'b1;
`else
                  r_rx_valid <= 1'b1;
`endif
                  r_rx_state <= RX_IDLE;
                end
              end
            endcase
          end
        end
        RX_BREAK: begin
          // Hold off new frames until the line has returned high.
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // RX FIFO
  // ------------------------------------------------------------------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
  logic [RX_CW-1:0] r_rx_count;
  logic             w_rx_full, w_rx_nempty, w_rx_push, w_rx_ovr_set;

  assign w_rx_full    = (r_rx_count == C_RX_FULL);
  assign w_rx_nempty  = (r_rx_count != '0);
  assign w_rx_pop     = w_rd & (bus.A == 2'd0) & w_rx_nempty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_rx_push    = r_rx_valid & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr_set = r_rx_valid & w_rx_full & ~w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) rx_mem[r_rx_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Registers, sticky flags, read mux, interrupt
  // ------------------------------------------------------------------------
  logic [1:0] r_ctrl;
  logic       r_tx_ovr, r_rx_ovr, r_ferr, w_perr_bit;
  logic [7:0] r_to_cpu, w_status, w_cnt8;
  logic [8:0] w_rx_cnt9;

`ifdef UART_PARITY_EN
  logic r_perr;
  assign w_perr_bit = r_perr;
`else
  assign w_perr_bit = 1'b0;
`endif

  assign w_status  = {w_perr_bit, r_ferr, w_rx_full, w_tx_idle,
                      w_rx_nempty, ~w_tx_full, r_rx_ovr, r_tx_ovr};
  assign w_rx_cnt9 = 9'(r_rx_count);
  assign w_cnt8    = w_rx_cnt9[8] ? 8'hFF : w_rx_cnt9[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= 2'b00;
      r_tx_ovr <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr   <= 1'b0;
`endif
      r_to_cpu <= 8'h00;
    end else begin
      if (w_ctrl_wr) r_ctrl <= bus.from_CPU[1:0];
      // Clear on STATUS read, but a set in the same cycle survives.
      r_tx_ovr <= (r_tx_ovr & ~w_stat_rd) | (w_tx_push_req & w_tx_full);
      r_rx_ovr <= (r_rx_ovr & ~w_stat_rd) | w_rx_ovr_set;
      r_ferr   <= (r_ferr   & ~w_stat_rd) | r_ferr_set;
`ifdef UART_PARITY_EN
      r_perr   <= (r_perr   & ~w_stat_rd) | r_perr_set;
`endif
      case (bus.A)
        2'd0:    r_to_cpu <= w_rx_nempty ? rx_mem[r_rx_rp] : 8'h00;
        2'd1:    r_to_cpu <= w_status;
        2'd2:    r_to_cpu <= {6'b0, r_ctrl};
        default: r_to_cpu <= w_cnt8;
      endcase
    end
  end

  assign bus.to_CPU = r_to_cpu;
  assign bus.irq    = (r_ctrl[0] & w_rx_nempty) | (r_ctrl[1] & w_tx_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_port
//  Purpose  : Self-checking bench for uart_port (CLK_DIV=8, depths 4).
//             Random bytes go through a queue-based model of the FIFOs and a
//             bit-level frame monitor on txd; RX frames are driven by a task.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_port;
  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 4;
  localparam int BIT_NS  = CLK_DIV * 10;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd, rxd;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  logic mon_en = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;
  assign rxd = loop ? txd : rxd_drv;

  uart_port_if bus();

  uart_port #(.CLK_DIV(CLK_DIV), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .rxd(rxd), .txd(txd));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.A = a; bus.from_CPU = d; bus.CE = 1'b1; bus.WREN = 1'b1;
    step(1);
    bus.CE = 1'b0; bus.WREN = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    bus.A = a; bus.CE = 1'b1; bus.REN = 1'b1;
    step(1);
    bus.CE = 1'b0; bus.REN = 1'b0;
    d = bus.to_CPU;
  endtask

  // Drives one serial frame on rxd_drv, followed by two idle bit times.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic flip_par);
    rxd_drv = 1'b0; step(CLK_DIV);
    for (int i = 0; i < 8; i++) begin rxd_drv = d[i]; step(CLK_DIV); end
`ifdef UART_PARITY_EN
    rxd_drv = (^d) ^ flip_par; step(CLK_DIV);
`endif
    rxd_drv = stop; step(CLK_DIV);
    rxd_drv = 1'b1; step(2 * CLK_DIV);
  endtask

  // Expected STATUS word from model-level facts.
  function automatic logic [7:0] stat(input bit perr, input bit ferr, input int rxn,
                                      input bit tx_idle, input bit tx_nfull,
                                      input bit rx_ovr, input bit tx_ovr);
    return {perr, ferr, rxn >= DEPTH, tx_idle, rxn > 0, tx_nfull, rx_ovr, tx_ovr};
  endfunction

  // Frame monitor: decodes every txd frame at mid-bit and compares it to the
  // bytes the model says were accepted into the TX FIFO.
  initial begin : g_tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge txd);
      if (mon_en && !reset) begin
        #(BIT_NS / 2 + 2);
        check_eq("mon_start", txd, 1'b0);
        for (int i = 0; i < 8; i++) begin #(BIT_NS); b[i] = txd; end
`ifdef UART_PARITY_EN
        #(BIT_NS);
        check_eq("mon_parity", txd, ^b);
`endif
        #(BIT_NS);
        check_eq("mon_stop", txd, 1'b1);
        check_eq("mon_frame_expected", txq.size() != 0, 1'b1);
        if (txq.size() != 0) check_eq("mon_byte", b, txq.pop_front());
      end
    end
  end

  initial begin : g_watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : g_main
    logic [7:0] rd, d, st;
    logic [NBITS-1:0] exp_bits;
    int n, k, errs;

    bus.A = 2'd0; bus.CE = 1'b0; bus.REN = 1'b0; bus.WREN = 1'b0; bus.from_CPU = 8'h00;

    // ---------------- reset state
    step(3);
    check_eq("rst_to_cpu", bus.to_CPU, 8'h00);
    check_eq("rst_txd", txd, 1'b1);
    check_eq("rst_irq", bus.irq, 1'b0);
    reset = 1'b0;
    step(2);
    cpu_read(2'd2, rd); check_eq("rst_ctrl", rd, 8'h00);
    cpu_read(2'd1, rd); check_eq("rst_status", rd, stat(0, 0, 0, 1, 1, 0, 0));
    cpu_read(2'd3, rd); check_eq("rst_count", rd, 8'h00);

    // ---------------- single frame waveform, exact bit timing
    cpu_write(2'd0, 8'h55); txq.push_back(8'h55);
    k = 0;
    while (txd !== 1'b0 && k < 20) begin step(1); k++; end
    check_eq("t1_start_seen", txd, 1'b0);
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    d = 8'h55;
    for (int i = 0; i < 8; i++) exp_bits[i + 1] = d[i];
`ifdef UART_PARITY_EN
    exp_bits[9] = ^d;
`endif
    errs = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (txd !== exp_bits[c / CLK_DIV]) errs++;
      if (c == 20) begin bus.A = 2'd1; bus.CE = 1'b1; bus.REN = 1'b1; end
      if (c == 21) begin bus.CE = 1'b0; bus.REN = 1'b0; st = bus.to_CPU; end
      step(1);
    end
    check_eq("t1_waveform_errors", errs, 0);
    check_eq("t1_tx_idle_during", st[4], 1'b0);
    step(5);
    cpu_read(2'd1, rd); check_eq("t1_status_after", rd, stat(0, 0, 0, 1, 1, 0, 0));

    // ---------------- random TX bursts into an idle port
    cpu_write(2'd2, 8'h02);
    for (int r = 0; r < 5; r++) begin
      n = (r == 0) ? 6 : $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        if (i < DEPTH + 1) txq.push_back(d);
        cpu_write(2'd0, d);
      end
      check_eq("burst_irq_busy", bus.irq, 1'b0);
      cpu_read(2'd1, rd);
      check_eq("burst_status_busy", rd, stat(0, 0, 0, 0, n <= DEPTH, 0, n > DEPTH + 1));
      step((n + 1) * FRAME + 20);
      check_eq("burst_irq_idle", bus.irq, 1'b1);
      cpu_read(2'd1, rd); check_eq("burst_status_idle", rd, stat(0, 0, 0, 1, 1, 0, 0));
    end

    // ---------------- loopback, random bytes, rx interrupt
    loop = 1'b1;
    cpu_write(2'd2, 8'h01);
    cpu_read(2'd2, rd); check_eq("ctrl_readback", rd, 8'h01);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        txq.push_back(d); rxq.push_back(d);
        cpu_write(2'd0, d);
      end
      step((n + 1) * FRAME + 40);
      check_eq("lb_irq_rx", bus.irq, 1'b1);
      cpu_read(2'd3, rd); check_eq("lb_count", rd, n);
      cpu_read(2'd1, rd); check_eq("lb_status", rd, stat(0, 0, n, 1, 1, 0, 0));
      while (rxq.size() != 0) begin
        cpu_read(2'd0, rd); check_eq("lb_pop", rd, rxq.pop_front());
      end
      cpu_read(2'd3, rd); check_eq("lb_count_empty", rd, 8'h00);
      cpu_read(2'd0, rd); check_eq("lb_pop_empty", rd, 8'h00);
      check_eq("lb_irq_clear", bus.irq, 1'b0);
    end
    loop = 1'b0;
    step(10);

    // ---------------- RX overrun with directly driven frames
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 8'($urandom);
      if (rxq.size() < DEPTH) rxq.push_back(d);
      send_byte(d, 1'b1, 1'b0);
    end
    cpu_read(2'd3, rd); check_eq("ovr_count", rd, DEPTH);
    cpu_read(2'd1, rd); check_eq("ovr_status", rd, stat(0, 0, DEPTH, 1, 1, 1, 0));
    while (rxq.size() != 0) begin
      cpu_read(2'd0, rd); check_eq("ovr_pop", rd, rxq.pop_front());
    end
    cpu_read(2'd0, rd); check_eq("ovr_pop_empty", rd, 8'h00);
    cpu_read(2'd1, rd); check_eq("ovr_status_clr", rd, stat(0, 0, 0, 1, 1, 0, 0));

    // ---------------- framing error and start glitch
    send_byte(8'($urandom), 1'b0, 1'b0);
    cpu_read(2'd1, rd); check_eq("ferr_status", rd, stat(0, 1, 0, 1, 1, 0, 0));
    cpu_read(2'd3, rd); check_eq("ferr_count", rd, 8'h00);
    rxd_drv = 1'b0; step(2); rxd_drv = 1'b1; step(4 * CLK_DIV);
    cpu_read(2'd1, rd); check_eq("glitch_status", rd, stat(0, 0, 0, 1, 1, 0, 0));
    cpu_read(2'd3, rd); check_eq("glitch_count", rd, 8'h00);
    d = 8'($urandom);
    send_byte(d, 1'b1, 1'b0);
    cpu_read(2'd0, rd); check_eq("post_err_byte", rd, d);

`ifdef UART_PARITY_EN
    // ---------------- parity error
    send_byte(8'h07, 1'b1, 1'b1);
    cpu_read(2'd1, rd); check_eq("perr_status", rd, stat(1, 0, 0, 1, 1, 0, 0));
    cpu_read(2'd3, rd); check_eq("perr_count", rd, 8'h00);
`endif

    // ---------------- asynchronous reset mid TX frame
    send_byte(8'($urandom), 1'b1, 1'b0);
    mon_en = 1'b0;
    cpu_write(2'd2, 8'h03);
    cpu_write(2'd0, 8'h00);
    cpu_write(2'd0, 8'($urandom));
    cpu_write(2'd0, 8'($urandom));
    k = 0;
    while (txd !== 1'b0 && k < 20) begin step(1); k++; end
    check_eq("rst6_start_seen", txd, 1'b0);
    step(3 * CLK_DIV);
    #2 reset = 1'b1;
    #1 check_eq("rst6_txd_async", txd, 1'b1);
    step(2);
    reset = 1'b0;
    step(1);
    check_eq("rst6_irq", bus.irq, 1'b0);
    cpu_read(2'd2, rd); check_eq("rst6_ctrl", rd, 8'h00);
    cpu_read(2'd1, rd); check_eq("rst6_status", rd, stat(0, 0, 0, 1, 1, 0, 0));
    cpu_read(2'd3, rd); check_eq("rst6_count", rd, 8'h00);
    step(2 * FRAME);
    check_eq("rst6_txd_idle", txd, 1'b1);
    mon_en = 1'b1;

    check_eq("tx_frames_left", txq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
